// File: rtl/id_ex_alu_issue_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_alu_issue_pkg
// Shared definitions for the ID/EX issue stage and the ALU:
//   - func_t      : 4-bit ALU function code
//   - OP_* / FN_* : MIPS opcode and R-type funct constants
//   - src2_t      : selector for the second ALU operand
//   - dec_t       : bundle produced by alu_decode
//   - ex_t        : contents of the ID/EX output register
// ----------------------------------------------------------------------------
package id_ex_alu_issue_pkg;

  typedef enum logic [3:0] {
    FUNC_AND  = 4'b0000,
    FUNC_OR   = 4'b0001,
    FUNC_ADD  = 4'b0010,
    FUNC_XOR  = 4'b0011,
    FUNC_XNOR = 4'b0100,
    FUNC_LUI  = 4'b0101,
    FUNC_SLT  = 4'b0111,
    FUNC_SUB  = 4'b1010
  } func_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [1:0] {
    SRC2_RT   = 2'd0,
    SRC2_SEXT = 2'd1,
    SRC2_ZEXT = 2'd2,
    SRC2_ZERO = 2'd3
  } src2_t;

  typedef struct packed {
    func_t func;
    src2_t src2;
    logic  in1_imm;
    logic  dest_rt;
    logic  reg_write;
    logic  mem_read;
    logic  mem_write;
    logic  uses_rs;
    logic  uses_rt;
    logic  illegal;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  wr_reg;
    func_t       func;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] store_data;
  } ex_t;

endpackage

// File: rtl/id_ex_alu_issue_alu_decode.sv
// ----------------------------------------------------------------------------
// alu_decode
// Purely combinational decode of a MIPS opcode/funct pair into the ALU
// function, second-operand source, destination choice, memory/writeback
// controls, source-register usage and an illegal flag.
//   op_i    : instruction bits [31:26]
//   funct_i : instruction bits [5:0]
//   dec_o   : decoded control bundle (dec_t)
// ----------------------------------------------------------------------------
module alu_decode
  import id_ex_alu_issue_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  // Source usage follows the load-use rules: rs is read by everything but
  // lui, rt only by R-type and sw. Unsupported encodings drop all controls.
  always_comb begin
    dec_o         = '0;
    dec_o.func    = FUNC_AND;
    dec_o.src2    = SRC2_RT;
    dec_o.uses_rs = (op_i != OP_LUI);
    dec_o.uses_rt = (op_i == OP_RTYPE) || (op_i == OP_SW);
    case (op_i)
      OP_RTYPE: begin
        dec_o.reg_write = 1'b1;
        case (funct_i)
          FN_ADD, FN_ADDU: dec_o.func = FUNC_ADD;
          FN_SUB, FN_SUBU: dec_o.func = FUNC_SUB;
          FN_AND:          dec_o.func = FUNC_AND;
          FN_OR:           dec_o.func = FUNC_OR;
          FN_XOR:          dec_o.func = FUNC_XOR;
          FN_SLT, FN_SLTU: dec_o.func = FUNC_SLT;
          default:         dec_o.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dec_o.func      = (op_i == OP_ADDI || op_i == OP_ADDIU) ? FUNC_ADD : FUNC_SLT;
        dec_o.src2      = SRC2_SEXT;
        dec_o.dest_rt   = 1'b1;
        dec_o.reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_o.func      = (op_i == OP_ANDI) ? FUNC_AND :
                          (op_i == OP_ORI)  ? FUNC_OR  : FUNC_XOR;
        dec_o.src2      = SRC2_ZEXT;
        dec_o.dest_rt   = 1'b1;
        dec_o.reg_write = 1'b1;
      end
      OP_LUI: begin
        dec_o.func      = FUNC_LUI;
        dec_o.src2      = SRC2_ZERO;
        dec_o.in1_imm   = 1'b1;
        dec_o.dest_rt   = 1'b1;
        dec_o.reg_write = 1'b1;
      end
      OP_LW: begin
        dec_o.func      = FUNC_ADD;
        dec_o.src2      = SRC2_SEXT;
        dec_o.dest_rt   = 1'b1;
        dec_o.reg_write = 1'b1;
        dec_o.mem_read  = 1'b1;
      end
      OP_SW: begin
        dec_o.func      = FUNC_ADD;
        dec_o.src2      = SRC2_SEXT;
        dec_o.dest_rt   = 1'b1;
        dec_o.mem_write = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
    if (dec_o.illegal) begin
      dec_o.reg_write = 1'b0;
      dec_o.mem_read  = 1'b0;
      dec_o.mem_write = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ----------------------------------------------------------------------------
// id_ex_alu_issue
// ID/EX pipeline register with decode, operand forwarding and load-use
// hazard detection. A decoded instruction appears on the outputs exactly one
// cycle after it is presented.
//   clk, rst           : clock, synchronous active-high reset
//   id_valid, id_instr : instruction from ID
//   id_rs_data/rt_data : register-file read data
//   ex_alu_result      : ALU result of the instruction held here (forwarding)
//   wb_we/reg/data     : writeback-stage forwarding source
//   stall, flush       : freeze output register / kill captured instruction
//   id_hold            : combinational load-use hold request to ID/IF
//   ex_valid, In1, In2, Func, ex_wr_reg, ex_reg_write, ex_mem_read,
//   ex_mem_write, ex_store_data, ex_illegal : registered EX-stage outputs
// ----------------------------------------------------------------------------
module id_ex_alu_issue
  import id_ex_alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] ex_alu_result,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        stall,
  input  logic        flush,
  output logic        id_hold,
  output logic        ex_valid,
  output logic [31:0] In1,
  output logic [31:0] In2,
  output func_t       Func,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_store_data,
  output logic        ex_illegal
);

  localparam ex_t EX_BUBBLE = '0;

  ex_t         ex_q, ex_d, capture;
  dec_t        dec;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] rs_fwd, rt_fwd;
  logic        shamt_unused;

  assign rs           = id_instr[25:21];
  assign rt           = id_instr[20:16];
  assign rd           = id_instr[15:11];
  assign imm          = id_instr[15:0];
  assign shamt_unused = ^id_instr[10:6];

  alu_decode u_alu_decode (
    .op_i    (id_instr[31:26]),
    .funct_i (id_instr[5:0]),
    .dec_o   (dec)
  );

  // A load's result is not available as ex_alu_result, so it never forwards
  // from EX; that case is covered by the load-use hold instead.
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf,
                                      input ex_t ex, input logic [31:0] alu,
                                      input logic we, input logic [4:0] wreg,
                                      input logic [31:0] wdata);
    if (idx == 5'd0)
      return rf;
    else if (ex.valid && ex.reg_write && !ex.mem_read && ex.wr_reg == idx)
      return alu;
    else if (we && wreg == idx)
      return wdata;
    else
      return rf;
  endfunction

  assign rs_fwd = fwd(rs, id_rs_data, ex_q, ex_alu_result, wb_we, wb_reg, wb_data);
  assign rt_fwd = fwd(rt, id_rt_data, ex_q, ex_alu_result, wb_we, wb_reg, wb_data);

  assign id_hold = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.wr_reg != 5'd0) &&
                   ((dec.uses_rs && rs == ex_q.wr_reg) || (dec.uses_rt && rt == ex_q.wr_reg));

  // Build the candidate register contents for the instruction in ID.
  always_comb begin
    capture = EX_BUBBLE;
    if (dec.illegal) begin
      capture.illegal = 1'b1;
    end else begin
      capture.valid      = 1'b1;
      capture.func       = dec.func;
      capture.in1        = dec.in1_imm ? {16'h0000, imm} : rs_fwd;
      case (dec.src2)
        SRC2_SEXT: capture.in2 = {{16{imm[15]}}, imm};
        SRC2_ZEXT: capture.in2 = {16'h0000, imm};
        SRC2_ZERO: capture.in2 = 32'h0;
        default:   capture.in2 = rt_fwd;
      endcase
      capture.wr_reg     = dec.dest_rt ? rt : rd;
      capture.reg_write  = dec.reg_write && (capture.wr_reg != 5'd0);
      capture.mem_read   = dec.mem_read;
      capture.mem_write  = dec.mem_write;
      capture.store_data = rt_fwd;
    end
  end

  // Edge priority: flush, then stall (hold everything), then load-use bubble.
  always_comb begin
    ex_d = ex_q;
    if (flush)
      ex_d = EX_BUBBLE;
    else if (stall)
      ex_d = ex_q;
    else if (id_hold)
      ex_d = EX_BUBBLE;
    else if (id_valid)
      ex_d = capture;
    else
      ex_d = EX_BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ex_q <= EX_BUBBLE;
    else
      ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_illegal    = ex_q.illegal;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_wr_reg     = ex_q.wr_reg;
  assign Func          = ex_q.func;
  assign In1           = ex_q.in1;
  assign In2           = ex_q.in2;
  assign ex_store_data = ex_q.store_data;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// ----------------------------------------------------------------------------
// tb_id_ex_alu_issue
// Self-checking bench for id_ex_alu_issue: a table of single-instruction
// vectors, hand-written multi-cycle sequences (forwarding, load-use, stall,
// flush, reset, illegal) and a randomized run against a behavioural model.
// ----------------------------------------------------------------------------
module tb_id_ex_alu_issue;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic        regw;
    logic        memr;
    logic        memw;
    logic [4:0]  wr;
    logic [3:0]  func;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] sd;
  } st_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rsd;
    logic [31:0] rtd;
    st_t         e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, wb_we, stall, flush;
  logic [31:0] id_instr, id_rs_data, id_rt_data, ex_alu_result, wb_data;
  logic [4:0]  wb_reg;
  logic        id_hold, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
  logic [31:0] In1, In2, ex_store_data;
  logic [3:0]  Func;
  logic [4:0]  ex_wr_reg;

  int checks = 0;
  int failures = 0;
  st_t exp_q;
  vec_t vt[15];

  id_ex_alu_issue dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .ex_alu_result(ex_alu_result),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .stall(stall), .flush(flush),
    .id_hold(id_hold), .ex_valid(ex_valid), .In1(In1), .In2(In2), .Func(Func),
    .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(int s, int t, int d, logic [5:0] fn);
    logic [4:0] s5, t5, d5;
    s5 = 5'(s); t5 = 5'(t); d5 = 5'(d);
    return {6'b000000, s5, t5, d5, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, int s, int t, logic [15:0] imm);
    logic [4:0] s5, t5;
    s5 = 5'(s); t5 = 5'(t);
    return {op, s5, t5, imm};
  endfunction

  function automatic st_t mkSt(logic v, logic il, logic rw, logic mr, logic mw, int wr,
                               logic [3:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] sd);
    st_t r;
    r.valid = v; r.illegal = il; r.regw = rw; r.memr = mr; r.memw = mw;
    r.wr = 5'(wr); r.func = f; r.in1 = a; r.in2 = b; r.sd = sd;
    return r;
  endfunction

  // Behavioural reference: instruction semantics straight from the ISA rules,
  // applied to already-forwarded operand values a (rs) and b (rt).
  function automatic st_t modelDecode(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
    st_t r;
    logic [5:0] op, fn;
    logic [31:0] sext, zext;
    logic ok;
    op = ins[31:26]; fn = ins[5:0];
    sext = {{16{ins[15]}}, ins[15:0]};
    zext = {16'h0, ins[15:0]};
    r = '0; ok = 1'b1;
    r.in1 = a; r.regw = 1'b1; r.wr = ins[20:16]; r.in2 = sext;
    if (op == 6'h00) begin
      r.in2 = b; r.wr = ins[15:11];
      if (fn == 6'h20 || fn == 6'h21) r.func = 4'b0010;
      else if (fn == 6'h22 || fn == 6'h23) r.func = 4'b1010;
      else if (fn == 6'h24) r.func = 4'b0000;
      else if (fn == 6'h25) r.func = 4'b0001;
      else if (fn == 6'h26) r.func = 4'b0011;
      else if (fn == 6'h2A || fn == 6'h2B) r.func = 4'b0111;
      else ok = 1'b0;
    end
    else if (op == 6'h08 || op == 6'h09) r.func = 4'b0010;
    else if (op == 6'h0A || op == 6'h0B) r.func = 4'b0111;
    else if (op == 6'h0C) begin r.func = 4'b0000; r.in2 = zext; end
    else if (op == 6'h0D) begin r.func = 4'b0001; r.in2 = zext; end
    else if (op == 6'h0E) begin r.func = 4'b0011; r.in2 = zext; end
    else if (op == 6'h0F) begin r.func = 4'b0101; r.in1 = zext; r.in2 = 32'h0; end
    else if (op == 6'h23) begin r.func = 4'b0010; r.memr = 1'b1; end
    else if (op == 6'h2B) begin r.func = 4'b0010; r.memw = 1'b1; r.regw = 1'b0; end
    else ok = 1'b0;
    if (!ok) begin
      r = '0; r.illegal = 1'b1;
    end else begin
      r.valid = 1'b1; r.sd = b;
      if (r.wr == 5'd0) r.regw = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] modelFwd(logic [4:0] idx, logic [31:0] rf);
    if (idx == 0) return rf;
    if (exp_q.valid && exp_q.regw && !exp_q.memr && exp_q.wr == idx) return ex_alu_result;
    if (wb_we && wb_reg == idx) return wb_data;
    return rf;
  endfunction

  function automatic logic modelHold();
    logic [5:0] op;
    logic usesRs, usesRt;
    op = id_instr[31:26];
    usesRs = (op != 6'h0F) && (id_instr[25:21] == exp_q.wr);
    usesRt = (op == 6'h00 || op == 6'h2B) && (id_instr[20:16] == exp_q.wr);
    return id_valid && exp_q.valid && exp_q.memr && exp_q.wr != 0 && (usesRs || usesRt);
  endfunction

  function automatic logic [31:0] pickInstr();
    int k, s, t, d;
    logic [5:0] fn, op;
    k = $urandom_range(0, 15);
    s = $urandom_range(0, 7); t = $urandom_range(0, 7); d = $urandom_range(0, 7);
    case ($urandom_range(0, 10))
      0: fn = 6'h20; 1: fn = 6'h21; 2: fn = 6'h22; 3: fn = 6'h23; 4: fn = 6'h24;
      5: fn = 6'h25; 6: fn = 6'h26; 7: fn = 6'h2A; 8: fn = 6'h2B; 9: fn = 6'h00;
      default: fn = 6'h27;
    endcase
    op = 6'(8 + $urandom_range(0, 6));
    if (k < 4) return rtype(s, t, d, fn);
    if (k < 10) return itype(op, s, t, 16'($urandom));
    if (k < 12) return itype(6'h23, s, t, 16'($urandom));
    if (k < 14) return itype(6'h2B, s, t, 16'($urandom));
    if (k == 14) return itype(6'h0F, s, t, 16'($urandom));
    return itype(($urandom_range(0, 1) != 0) ? 6'h02 : 6'h04, s, t, 16'($urandom));
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag, st_t e);
    cmp({tag, ".ex_valid"}, 32'(ex_valid), 32'(e.valid));
    cmp({tag, ".ex_illegal"}, 32'(ex_illegal), 32'(e.illegal));
    cmp({tag, ".reg_write"}, 32'(ex_reg_write), 32'(e.regw));
    cmp({tag, ".mem_read"}, 32'(ex_mem_read), 32'(e.memr));
    cmp({tag, ".mem_write"}, 32'(ex_mem_write), 32'(e.memw));
    if (e.valid) begin
      cmp({tag, ".Func"}, 32'(Func), 32'(e.func));
      cmp({tag, ".In1"}, In1, e.in1);
      cmp({tag, ".In2"}, In2, e.in2);
      cmp({tag, ".wr_reg"}, 32'(ex_wr_reg), 32'(e.wr));
    end
    if (e.memw) cmp({tag, ".store_data"}, ex_store_data, e.sd);
  endtask

  task automatic checkResetValues(string tag);
    cmp({tag, ".ex_valid"}, 32'(ex_valid), 0);
    cmp({tag, ".ex_illegal"}, 32'(ex_illegal), 0);
    cmp({tag, ".reg_write"}, 32'(ex_reg_write), 0);
    cmp({tag, ".mem_read"}, 32'(ex_mem_read), 0);
    cmp({tag, ".mem_write"}, 32'(ex_mem_write), 0);
    cmp({tag, ".In1"}, In1, 0);
    cmp({tag, ".In2"}, In2, 0);
    cmp({tag, ".store_data"}, ex_store_data, 0);
    cmp({tag, ".Func"}, 32'(Func), 0);
    cmp({tag, ".wr_reg"}, 32'(ex_wr_reg), 0);
  endtask

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; id_instr = 32'h0; id_rs_data = 32'h0; id_rt_data = 32'h0;
    ex_alu_result = 32'h0; wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'h0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q = '0;
  endtask

  task automatic applyStimulus(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
    id_valid = 1'b1; id_instr = ins; id_rs_data = a; id_rt_data = b;
    tick();
  endtask

  initial begin
    st_t nxt;
    logic h;

    vt[0]  = '{itype(6'h08, 8, 9, 16'hFFFB), 32'd123, 32'd0,
               mkSt(1, 0, 1, 0, 0, 9, 4'b0010, 32'd123, 32'hFFFFFFFB, 0)};
    vt[1]  = '{itype(6'h0C, 1, 2, 16'h8000), 32'hFFFFFFFF, 32'd0,
               mkSt(1, 0, 1, 0, 0, 2, 4'b0000, 32'hFFFFFFFF, 32'h00008000, 0)};
    vt[2]  = '{itype(6'h0F, 0, 4, 16'h1234), 32'd55, 32'd0,
               mkSt(1, 0, 1, 0, 0, 4, 4'b0101, 32'h00001234, 32'h0, 0)};
    vt[3]  = '{itype(6'h0A, 3, 5, 16'h8001), 32'd7, 32'd0,
               mkSt(1, 0, 1, 0, 0, 5, 4'b0111, 32'd7, 32'hFFFF8001, 0)};
    vt[4]  = '{itype(6'h0D, 3, 6, 16'h00F0), 32'h100, 32'd0,
               mkSt(1, 0, 1, 0, 0, 6, 4'b0001, 32'h100, 32'h000000F0, 0)};
    vt[5]  = '{itype(6'h0E, 1, 7, 16'hFFFF), 32'd1, 32'd0,
               mkSt(1, 0, 1, 0, 0, 7, 4'b0011, 32'd1, 32'h0000FFFF, 0)};
    vt[6]  = '{itype(6'h23, 2, 8, 16'hFFFC), 32'd1000, 32'd0,
               mkSt(1, 0, 1, 1, 0, 8, 4'b0010, 32'd1000, 32'hFFFFFFFC, 0)};
    vt[7]  = '{itype(6'h2B, 2, 9, 16'h0010), 32'd2000, 32'hDEAD,
               mkSt(1, 0, 0, 0, 1, 9, 4'b0010, 32'd2000, 32'h10, 32'hDEAD)};
    vt[8]  = '{rtype(1, 2, 0, 6'h20), 32'd5, 32'd6,
               mkSt(1, 0, 0, 0, 0, 0, 4'b0010, 32'd5, 32'd6, 0)};
    vt[9]  = '{rtype(1, 2, 3, 6'h22), 32'd10, 32'd3,
               mkSt(1, 0, 1, 0, 0, 3, 4'b1010, 32'd10, 32'd3, 0)};
    vt[10] = '{rtype(4, 5, 6, 6'h2B), 32'd11, 32'd12,
               mkSt(1, 0, 1, 0, 0, 6, 4'b0111, 32'd11, 32'd12, 0)};
    vt[11] = '{rtype(1, 2, 3, 6'h26), 32'hF0F0, 32'h0FF0,
               mkSt(1, 0, 1, 0, 0, 3, 4'b0011, 32'hF0F0, 32'h0FF0, 0)};
    vt[12] = '{{6'b000010, 26'h0000123}, 32'd1, 32'd2,
               mkSt(0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0)};
    vt[13] = '{rtype(1, 2, 3, 6'h00), 32'd1, 32'd2,
               mkSt(0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0)};
    vt[14] = '{itype(6'h09, 0, 1, 16'h0005), 32'd0, 32'd0,
               mkSt(1, 0, 1, 0, 0, 1, 4'b0010, 32'd0, 32'd5, 0)};

    doReset();
    checkResetValues("reset");

    // Table: each vector issued from a freshly reset stage (no forwarding).
    for (int i = 0; i < 15; i++) begin
      doReset();
      applyStimulus(vt[i].instr, vt[i].rsd, vt[i].rtd);
      checkOutput($sformatf("vec%0d", i), vt[i].e);
    end

    // Illegal flag lasts one cycle.
    doReset();
    applyStimulus(rtype(1, 2, 3, 6'h00), 1, 2);
    cmp("illegal_set", 32'(ex_illegal), 1);
    id_valid = 1'b0;
    tick();
    cmp("illegal_clear", 32'(ex_illegal), 0);

    // Forwarding: EX only, WB only, both (EX wins).
    doReset();
    applyStimulus(rtype(1, 2, 3, 6'h20), 5, 6);
    ex_alu_result = 32'd12464;
    applyStimulus(rtype(3, 1, 4, 6'h22), 99, 6);
    cmp("fwd_ex_in1", In1, 32'd12464);
    wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'd7; ex_alu_result = 32'd555;
    applyStimulus(rtype(3, 1, 4, 6'h22), 99, 6);
    cmp("fwd_wb_in1", In1, 32'd7);
    cmp("fwd_wb_in2", In2, 32'd6);
    wb_we = 1'b0;
    applyStimulus(rtype(1, 2, 3, 6'h20), 5, 6);
    wb_we = 1'b1; ex_alu_result = 32'd12464;
    applyStimulus(rtype(3, 1, 4, 6'h22), 99, 6);
    cmp("fwd_both_in1", In1, 32'd12464);

    // Load-use hold, bubble, then the dependent add issues.
    doReset();
    applyStimulus(itype(6'h23, 1, 5, 16'h0), 100, 0);
    cmp("lu_lw_memread", 32'(ex_mem_read), 1);
    id_instr = rtype(5, 2, 6, 6'h20);
    #1;
    cmp("lu_hold_set", 32'(id_hold), 1);
    tick();
    cmp("lu_bubble", 32'(ex_valid), 0);
    cmp("lu_hold_clear", 32'(id_hold), 0);
    applyStimulus(rtype(5, 2, 6, 6'h20), 77, 3);
    cmp("lu_add_valid", 32'(ex_valid), 1);
    cmp("lu_add_in1", In1, 32'd77);
    cmp("lu_add_wr", 32'(ex_wr_reg), 6);

    // Stall holds for 3 cycles; flush under stall; reset under stall.
    doReset();
    applyStimulus(itype(6'h08, 8, 9, 16'hFFFB), 123, 0);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(rtype(1, 2, 3, 6'h22), 1, 2);
      checkOutput($sformatf("stall%0d", c),
                  mkSt(1, 0, 1, 0, 0, 9, 4'b0010, 32'd123, 32'hFFFFFFFB, 0));
    end
    flush = 1'b1;
    tick();
    cmp("flush_in_stall", 32'(ex_valid), 0);
    flush = 1'b0; stall = 1'b0;
    applyStimulus(itype(6'h23, 1, 5, 16'h4), 40, 0);
    stall = 1'b1;
    id_instr = rtype(5, 2, 6, 6'h20);
    #1;
    cmp("stall_hold_comb", 32'(id_hold), 1);
    tick();
    cmp("stall_over_hold", 32'(ex_mem_read), 1);
    rst = 1'b1;
    tick();
    checkResetValues("rst_in_stall");
    rst = 1'b0; stall = 1'b0;
    applyStimulus(itype(6'h08, 8, 9, 16'hFFFB), 123, 0);
    cmp("post_rst_valid", 32'(ex_valid), 1);
    cmp("post_rst_in1", In1, 32'd123);

    // Randomized run against the behavioural model.
    doReset();
    for (int n = 0; n < 800; n++) begin
      rst           = ($urandom_range(0, 99) < 2);
      flush         = ($urandom_range(0, 99) < 5);
      stall         = ($urandom_range(0, 99) < 12);
      id_valid      = ($urandom_range(0, 99) < 80);
      id_instr      = pickInstr();
      id_rs_data    = $urandom;
      id_rt_data    = $urandom;
      ex_alu_result = $urandom;
      wb_we         = ($urandom_range(0, 1) != 0);
      wb_reg        = 5'($urandom_range(0, 7));
      wb_data       = $urandom;
      #1;
      h = modelHold();
      cmp("rand.id_hold", 32'(id_hold), 32'(h));
      if (rst || flush) nxt = '0;
      else if (stall) nxt = exp_q;
      else if (h || !id_valid) nxt = '0;
      else nxt = modelDecode(id_instr, modelFwd(id_instr[25:21], id_rs_data),
                             modelFwd(id_instr[20:16], id_rt_data));
      tick();
      exp_q = nxt;
      checkOutput("rand", exp_q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
